// File: rtl/dehaze_axis_out.sv
// Output stage of the dehaze pipeline: packs restored pixels into an AXI4-Stream
// master through a first-word fall-through FIFO, dropping frames on overflow.
module dehaze_axis_out #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    in_r,
  input  logic [7:0]    in_g,
  input  logic [7:0]    in_b,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic          in_eol,
  input  logic          clr_ovf,
  output logic [23:0]   m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tuser,
  output logic          m_tlast,
  output logic [AW:0]   level,
  output logic          ovf_sticky,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   drop_cnt
);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   frameCnt_q, frameCnt_d;
  logic [15:0]   dropCnt_q, dropCnt_d;
  logic [25:0]   mem_q [DEPTH];

  logic          pop;
  logic          push;
  logic          space;
  logic          dropEvt;
  logic [25:0]   head;

  assign head     = mem_q[rdPtr_q];
  assign m_tvalid = (level_q != '0);
  assign m_tuser  = head[25];
  assign m_tlast  = head[24];
  assign m_tdata  = head[23:0];
  assign level      = level_q;
  assign ovf_sticky = ovf_q;
  assign frame_cnt  = frameCnt_q;
  assign drop_cnt   = dropCnt_q;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign pop   = m_tvalid && m_tready;
  assign space = (level_q < FULL) || pop;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    dropEvt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_sof && space) begin
          push    = 1'b1;
          state_d = PASS;
        end
      end
      PASS: begin
        if (in_valid) begin
          if (space) begin
            push = 1'b1;
          end else begin
            dropEvt = 1'b1;
            state_d = DROP;
          end
        end
      end
      DROP: begin
        if (in_valid && in_sof && space) begin
          push    = 1'b1;
          state_d = PASS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wrPtr_d    = push ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d    = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
    level_d    = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!push && pop) begin
      level_d = level_q - 1'b1;
    end
    frameCnt_d = (push && in_sof) ? frameCnt_q + 1'b1 : frameCnt_q;
    dropCnt_d  = (dropEvt && dropCnt_q != 16'hFFFF) ? dropCnt_q + 1'b1 : dropCnt_q;
    // A new overflow wins over a clear arriving in the same cycle.
    ovf_d = ovf_q;
    if (dropEvt) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      frameCnt_q <= '0;
      dropCnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      frameCnt_q <= frameCnt_d;
      dropCnt_q  <= dropCnt_d;
    end
  end

  // Storage needs no reset: its contents are ignored while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= {in_sof, in_eol, in_r, in_g, in_b};
    end
  end

endmodule

// File: doc/dehaze_axis_out.md
DEHAZE_AXIS_OUT -- requirements
Module: dehaze_axis_out

Interface
REQ-001 Parameter: DEPTH, 16, FIFO entries; power of two, >= 4.
REQ-002 Parameter: AW, 4, FIFO address width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  clock; all state SHALL be updated on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_r / in_g / in_b  input  8 each  restored pixel from the dehaze pipeline output.
REQ-006 in_valid / in_sof / in_eol  input  1 each  pixel strobe, frame start, line end; the source has no backpressure.
REQ-007 clr_ovf  input  1  synchronous clear of ovf_sticky.
REQ-008 m_tdata  output  24  {r,g,b} with r in [23:16].
REQ-009 m_tvalid / m_tready  output / input  1 each  AXI4-Stream handshake.
REQ-010 m_tuser / m_tlast  output  1 each  carry the pixel's sof / eol.
REQ-011 level  output  AW+1  current FIFO occupancy, 0..DEPTH.
REQ-012 ovf_sticky  output  1  set on any dropped pixel.
REQ-013 frame_cnt / drop_cnt  output  16 each  accepted frames / frames truncated by overflow.

Function
REQ-014 Each FIFO entry SHALL be {sof, eol, r, g, b} (26 bits), held in a circular buffer with AW-bit read and write pointers that wrap modulo DEPTH.
REQ-015 The output SHALL be first-word fall-through:
- m_tvalid = (level != 0);
- m_tdata, m_tuser and m_tlast SHALL show the head entry.
REQ-016 A pop SHALL occur when m_tvalid && m_tready.
- m_tdata, m_tuser and m_tlast SHALL stay stable while m_tvalid && !m_tready.
REQ-017 Latency: a pixel written at edge N into an empty FIFO SHALL appear with m_tvalid=1 after edge N.
REQ-018 space = (level < DEPTH) || pop.
- A push and a pop in the same cycle when full SHALL both occur and leave level at DEPTH.
REQ-019 The control FSM SHALL have three states: IDLE, PASS, DROP.
REQ-020 IDLE:
- in_valid && in_sof && space -> push the pixel, go to PASS;
- every other in_valid pixel -> discarded, with no flag.
REQ-021 PASS:
- in_valid && space -> push;
- in_valid && !space -> discard the pixel, set ovf_sticky, increment drop_cnt (saturating at 0xFFFF), go to DROP.
REQ-022 PASS with in_sof arriving mid-frame SHALL be accepted as a new frame.
REQ-023 DROP:
- discard all pixels until in_valid && in_sof && space, which pushes the pixel and goes to PASS;
- an sof seen while !space SHALL keep the FSM in DROP and discard that pixel, with no additional drop_cnt increment.
REQ-024 frame_cnt SHALL increment, wrapping, on every pushed pixel with sof=1.
REQ-025 level SHALL change by:
- +1 on push only;
- -1 on pop only;
- 0 when both or neither occur.
REQ-026 clr_ovf SHALL clear ovf_sticky; a set event in the same cycle SHALL take priority.
REQ-027 Pixels with in_valid=0 SHALL be ignored regardless of in_sof or in_eol.

Reset
REQ-028 During rst_n=0, at all times, the block SHALL hold:
- FSM=IDLE, both pointers = 0, level=0;
- m_tvalid=0;
- ovf_sticky=0, frame_cnt=0, drop_cnt=0.
REQ-029 Assertion of rst_n mid-frame SHALL discard all buffered entries.
REQ-030 After deassertion, the block SHALL output nothing until a fresh sof.
REQ-031 m_tdata, m_tuser and m_tlast are don't-care while m_tvalid=0.

Verification
REQ-032 Pass-through: m_tready=1; stream 4x2 frame (values 0x010203 upward) with sof on the first pixel and eol on pixels 3 and 7.
- Expect 8 beats in order, tuser on beat 0, tlast on beats 3 and 7.
- Expect frame_cnt=1 and level never above 1.
REQ-033 Pre-sof garbage: 5 valid pixels without sof, then a frame.
- Expect only the frame's pixels on the output.
- Expect ovf_sticky=0.
REQ-034 Overflow: DEPTH=16, m_tready=0, push 20 pixels of one frame.
- Expect level=16 and ovf_sticky=1, drop_cnt=1.
- Expect the FIFO to hold pixels 0..15 and the FSM in DROP.
- Then m_tready=1: expect exactly 16 beats.
REQ-035 Recovery: after REQ-034, a further 3 non-sof pixels followed by a new sof frame.
- Expect the non-sof pixels to be dropped.
- Expect the new frame to be output intact, frame_cnt=2, drop_cnt still 1.
REQ-036 Full with simultaneous push/pop: level=16, m_tready=1, in_valid=1 every cycle for 10 cycles.
- Expect no drop and level held at 16.
REQ-037 Mid-frame reset: assert rst_n low with level=7.
- Expect m_tvalid=0 immediately and all counters 0.
- Expect nothing output until the next sof.
